sha256_compress: RTL and testbench
==================================

Name: sha256_compress

Overview:
- SHA-256 compression core that sits directly downstream of the message scheduler.
- Consumes one 32-bit schedule word W_t per qualified cycle and runs one round per word, 64 rounds in total.
- After round 63 it adds the working variables into the chaining hash H0..H7 and presents the 256-bit digest.
- Multi-block messages are supported: H persists between blocks until re-initialised.

Parameters:
- ROUNDS, 64, rounds per block; fixed by SHA-256, parameterised only for the round counter width.
- TW, 6, round counter width, equal to clog2(ROUNDS).

Ports:
- clk  input  1  clock, rising edge
- rst  input  1  asynchronous, active-low reset
- i_init  input  1  load the IV into H0..H7; honoured only in IDLE
- i_start  input  1  begin a block: a..h <= H0..H7; honoured only in IDLE
- i_w_valid  input  1  i_w is a valid schedule word this cycle
- i_w  input  32  schedule word W_t, in order t=0..63
- o_ready  output  1  high in IDLE, meaning i_start will be accepted
- o_busy  output  1  high in ROUND and FINAL
- o_done  output  1  one-cycle pulse when the digest has been updated
- o_digest  output  256  {H0,...,H7}, H0 in bits [255:224]; registered, always visible

Behaviour:
- Reset (rst=0, async):
  - state=IDLE, t=0, a..h=0.
  - H0..H7 = IV (6a09e667 bb67ae85 3c6ef372 a54ff53a 510e527f 9b05688c 1f83d9ab 5be0cd19).
  - o_done=0, o_busy=0, o_ready=1.
- States: IDLE, ROUND, FINAL.
- IDLE:
  - i_init=1 reloads H from the IV.
  - i_start=1 loads a..h from H, clears t, and moves to ROUND.
  - When i_init and i_start arrive together, a..h are loaded from the IV, not the old H.
  - i_w_valid is ignored.
- ROUND, on a cycle with i_w_valid=1:
  - T1 = h + Σ1(e) + Ch(e,f,g) + K[t] + i_w
  - T2 = Σ0(a) + Maj(a,b,c)
  - h<=g, g<=f, f<=e, e<=d+T1, d<=c, c<=b, b<=a, a<=T1+T2, t<=t+1.
  - All additions are mod 2^32; carries are discarded.
  - Σ0 = ROTR2^ROTR13^ROTR22; Σ1 = ROTR6^ROTR11^ROTR25.
  - Ch = (e&f)^(~e&g); Maj = (a&b)^(a&c)^(b&c).
- ROUND stall: with i_w_valid=0 all registers hold. Stalls of any length are legal.
- Last round: when t==63 and i_w_valid=1, the round is applied, t wraps to 0, and the state moves to FINAL.
- FINAL (exactly 1 cycle): Hi <= Hi + working variable i for i=0..7, with mod 2^32 addition. o_done<=1, state moves to IDLE.
- Latency:
  - The 64th valid word is sampled at edge N.
  - FINAL is occupied between edges N and N+1.
  - o_done=1 and the new o_digest are visible in the cycle after edge N+1.
  - o_ready returns in that same cycle.
  - i_start may be asserted in that cycle, giving back-to-back blocks.
- o_done is high for exactly one cycle per block and is never asserted otherwise.
- i_start or i_init while o_busy=1 is ignored and has no side effects.
- i_w_valid outside ROUND is ignored.
- Reset mid-operation returns immediately to the reset values. The partial block is discarded and no o_done is produced.
- K[t] is combinational from t with no lookup latency.

Decomposition:
- Package sha256_pkg holds:
  - IV constant array H_INIT[0:7] and round constant array K[0:63];
  - state encoding IDLE=2'd0, ROUND=2'd1, FINAL=2'd2;
  - pure functions big_sigma0, big_sigma1, ch, maj.
- Sub-module sha256_k_rom: combinational 6-bit address in, 32-bit K out, implemented as a case ROM.
- The round datapath stays inline.

Test Plan:
- "abc" single block:
  - Stimulus: i_init+i_start, then the 64 W words of the padded block (W0=61626380, W1..W14=0, W15=00000018; W16..W63 from a model), with i_w_valid held continuously.
  - Required: o_done 66 cycles after i_start and o_digest = ba7816bf 8f01cfea 414140de 5dae2223 b00361a3 96177a9c b410ff61 f20015ad.
- Empty message (W0=80000000, rest of the block 0):
  - Required: o_digest = e3b0c442 98fc1c14 9afbf4c8 996fb924 27ae41e4 649b934c a495991b 7852b855.
- Two-block "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq":
  - Stimulus: block 2 started with i_start only (no i_init), in the o_done cycle of block 1.
  - Required: final digest = 248d6a61 d20638b8 e5c02693 0c3e6039 a33ce459 64ff2167 f6ecedd4 19db06c1.
- Stalls:
  - Stimulus: "abc" with random i_w_valid gaps (1-5 cycles).
  - Required: the same digest as the "abc" case, o_done exactly once, and o_busy=1 throughout the gaps.
- Illegal requests:
  - Stimulus: i_start and i_init pulsed at t=10, plus stray i_w_valid while in IDLE.
  - Required: no effect; the "abc" digest is unchanged.
- Reset mid-operation:
  - Stimulus: rst=0 at t=30, released, then a fresh "abc" run.
  - Required: o_digest equals the IV immediately after reset, no o_done from the aborted block, and the fresh run produces the correct "abc" digest.

Source files
------------

// File: rtl/sha256_pkg.sv
// Shared constants, state encoding and round helper functions for the
// SHA-256 compression core.
package sha256_pkg;

  localparam logic [31:0] H_INIT [0:7] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    FINAL = 2'd2
  } state_t;

  function automatic logic [31:0] big_sigma0(input logic [31:0] x);
    return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
  endfunction

  function automatic logic [31:0] big_sigma1(input logic [31:0] x);
    return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
  endfunction

  function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f,
                                     input logic [31:0] g);
    return (e & f) ^ (~e & g);
  endfunction

  function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b,
                                      input logic [31:0] c);
    return (a & b) ^ (a & c) ^ (b & c);
  endfunction

endpackage

// File: rtl/sha256_k_rom.sv
// Combinational round-constant ROM: K[t] is available in the same cycle as t.
module sha256_k_rom (
  input  logic [5:0]  addr,
  output logic [31:0] k
);

  always_comb begin
    k = 32'h0;
    case (addr)
      6'd0:  k = 32'h428a2f98;
      6'd1:  k = 32'h71374491;
      6'd2:  k = 32'hb5c0fbcf;
      6'd3:  k = 32'he9b5dba5;
      6'd4:  k = 32'h3956c25b;
      6'd5:  k = 32'h59f111f1;
      6'd6:  k = 32'h923f82a4;
      6'd7:  k = 32'hab1c5ed5;
      6'd8:  k = 32'hd807aa98;
      6'd9:  k = 32'h12835b01;
      6'd10: k = 32'h243185be;
      6'd11: k = 32'h550c7dc3;
      6'd12: k = 32'h72be5d74;
      6'd13: k = 32'h80deb1fe;
      6'd14: k = 32'h9bdc06a7;
      6'd15: k = 32'hc19bf174;
      6'd16: k = 32'he49b69c1;
      6'd17: k = 32'hefbe4786;
      6'd18: k = 32'h0fc19dc6;
      6'd19: k = 32'h240ca1cc;
      6'd20: k = 32'h2de92c6f;
      6'd21: k = 32'h4a7484aa;
      6'd22: k = 32'h5cb0a9dc;
      6'd23: k = 32'h76f988da;
      6'd24: k = 32'h983e5152;
      6'd25: k = 32'ha831c66d;
      6'd26: k = 32'hb00327c8;
      6'd27: k = 32'hbf597fc7;
      6'd28: k = 32'hc6e00bf3;
      6'd29: k = 32'hd5a79147;
      6'd30: k = 32'h06ca6351;
      6'd31: k = 32'h14292967;
      6'd32: k = 32'h27b70a85;
      6'd33: k = 32'h2e1b2138;
      6'd34: k = 32'h4d2c6dfc;
      6'd35: k = 32'h53380d13;
      6'd36: k = 32'h650a7354;
      6'd37: k = 32'h766a0abb;
      6'd38: k = 32'h81c2c92e;
      6'd39: k = 32'h92722c85;
      6'd40: k = 32'ha2bfe8a1;
      6'd41: k = 32'ha81a664b;
      6'd42: k = 32'hc24b8b70;
      6'd43: k = 32'hc76c51a3;
      6'd44: k = 32'hd192e819;
      6'd45: k = 32'hd6990624;
      6'd46: k = 32'hf40e3585;
      6'd47: k = 32'h106aa070;
      6'd48: k = 32'h19a4c116;
      6'd49: k = 32'h1e376c08;
      6'd50: k = 32'h2748774c;
      6'd51: k = 32'h34b0bcb5;
      6'd52: k = 32'h391c0cb3;
      6'd53: k = 32'h4ed8aa4a;
      6'd54: k = 32'h5b9cca4f;
      6'd55: k = 32'h682e6ff3;
      6'd56: k = 32'h748f82ee;
      6'd57: k = 32'h78a5636f;
      6'd58: k = 32'h84c87814;
      6'd59: k = 32'h8cc70208;
      6'd60: k = 32'h90befffa;
      6'd61: k = 32'ha4506ceb;
      6'd62: k = 32'hbef9a3f7;
      6'd63: k = 32'hc67178f2;
      default: k = 32'h0;
    endcase
  end

endmodule

// File: rtl/sha256_compress.sv
// SHA-256 compression core: one round per valid schedule word, then a single
// FINAL cycle that folds the working variables into the chaining hash.
module sha256_compress
  import sha256_pkg::*;
#(
  parameter int ROUNDS = 64,
  parameter int TW     = $clog2(ROUNDS)
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_init,
  input  logic         i_start,
  input  logic         i_w_valid,
  input  logic [31:0]  i_w,
  output logic         o_ready,
  output logic         o_busy,
  output logic         o_done,
  output logic [255:0] o_digest
);

  localparam logic [TW-1:0] LAST_T = TW'(ROUNDS - 1);

  state_t        state;
  logic [TW-1:0] t;
  logic [31:0]   work [0:7];
  logic [31:0]   hash [0:7];
  logic          done;
  logic [31:0]   k_t;
  logic [31:0]   t1;
  logic [31:0]   t2;

  sha256_k_rom u_k_rom (
    .addr (t),
    .k    (k_t)
  );

  // work[0..7] hold a..h; all sums wrap naturally at 32 bits.
  assign t1 = work[7] + big_sigma1(work[4]) + ch(work[4], work[5], work[6]) + k_t + i_w;
  assign t2 = big_sigma0(work[0]) + maj(work[0], work[1], work[2]);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      t     <= '0;
      done  <= 1'b0;
      for (int i = 0; i < 8; i++) begin
        work[i] <= 32'h0;
        hash[i] <= H_INIT[i];
      end
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (i_init) begin
            for (int i = 0; i < 8; i++) hash[i] <= H_INIT[i];
          end
          // A simultaneous init must seed the block from the IV, not the stale H.
          if (i_start) begin
            for (int i = 0; i < 8; i++) work[i] <= i_init ? H_INIT[i] : hash[i];
            t     <= '0;
            state <= ROUND;
          end
        end
        ROUND: begin
          if (i_w_valid) begin
            work[0] <= t1 + t2;
            work[1] <= work[0];
            work[2] <= work[1];
            work[3] <= work[2];
            work[4] <= work[3] + t1;
            work[5] <= work[4];
            work[6] <= work[5];
            work[7] <= work[6];
            t       <= t + TW'(1);
            if (t == LAST_T) state <= FINAL;
          end
        end
        FINAL: begin
          for (int i = 0; i < 8; i++) hash[i] <= hash[i] + work[i];
          done  <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign o_ready  = (state == IDLE);
  assign o_busy   = (state == ROUND) || (state == FINAL);
  assign o_done   = done;
  assign o_digest = {hash[0], hash[1], hash[2], hash[3],
                     hash[4], hash[5], hash[6], hash[7]};

endmodule

// File: tb/tb_sha256_compress.sv
// Directed bench for sha256_compress using known SHA-256 test vectors; the
// message schedule is expanded by a small model inside the bench.
module tb_sha256_compress;

  typedef logic [31:0] block_t [0:15];

  localparam logic [255:0] IV_DIGEST =
    256'h6a09e667bb67ae853c6ef372a54ff53a510e527f9b05688c1f83d9ab5be0cd19;
  localparam logic [255:0] ABC_DIGEST =
    256'hba7816bf8f01cfea414140de5dae2223b00361a396177a9cb410ff61f20015ad;
  localparam logic [255:0] EMPTY_DIGEST =
    256'he3b0c44298fc1c149afbf4c8996fb92427ae41e4649b934ca495991b7852b855;
  localparam logic [255:0] TWO_DIGEST =
    256'h248d6a61d20638b8e5c026930c3e6039a33ce45964ff2167f6ecedd419db06c1;

  logic         clk;
  logic         rst;
  logic         i_init;
  logic         i_start;
  logic         i_w_valid;
  logic [31:0]  i_w;
  logic         o_ready;
  logic         o_busy;
  logic         o_done;
  logic [255:0] o_digest;

  int checks = 0;
  int errors = 0;
  int done_count = 0;
  int edges;

  block_t abc_blk, empty_blk, two_blk1, two_blk2;

  sha256_compress dut (
    .clk       (clk),
    .rst       (rst),
    .i_init    (i_init),
    .i_start   (i_start),
    .i_w_valid (i_w_valid),
    .i_w       (i_w),
    .o_ready   (o_ready),
    .o_busy    (o_busy),
    .o_done    (o_done),
    .o_digest  (o_digest)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Count o_done pulses on the falling edge, away from the updating edge.
  always @(negedge clk) if (o_done === 1'b1) done_count++;

  function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [31:0] small_sigma0(input logic [31:0] x);
    return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
  endfunction

  function automatic logic [31:0] small_sigma1(input logic [31:0] x);
    return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check_output(input string tag, input logic [255:0] observed,
                              input logic [255:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Drives one block; abort_at >= 0 pulls reset before word abort_at,
  // illegal_at >= 0 pulses i_start/i_init alongside word illegal_at.
  task automatic apply_stimulus(input string name, input bit do_init, input block_t m,
                                input bit stalls, input int illegal_at, input int abort_at);
    logic [31:0] w [0:63];
    for (int j = 0; j < 16; j++) w[j] = m[j];
    for (int j = 16; j < 64; j++)
      w[j] = small_sigma1(w[j-2]) + w[j-7] + small_sigma0(w[j-15]) + w[j-16];

    i_init    = do_init;
    i_start   = 1'b1;
    i_w_valid = 1'b0;
    tick();
    i_init  = 1'b0;
    i_start = 1'b0;
    edges   = 0;
    check_output({name, " busy after start"}, {255'b0, o_busy}, {255'b0, 1'b1});
    check_output({name, " ready after start"}, {255'b0, o_ready}, 256'b0);

    for (int j = 0; j < 64; j++) begin
      if (stalls && ($urandom_range(0, 2) == 0)) begin
        i_w_valid = 1'b0;
        i_w       = $urandom;
        repeat ($urandom_range(1, 5)) begin
          tick();
          edges++;
          check_output({name, " busy in gap"}, {255'b0, o_busy}, {255'b0, 1'b1});
        end
      end
      if (j == abort_at) begin
        rst = 1'b0;
        #1;
        check_output({name, " digest after abort"}, o_digest, IV_DIGEST);
        check_output({name, " ready after abort"}, {255'b0, o_ready}, {255'b0, 1'b1});
        check_output({name, " busy after abort"}, {255'b0, o_busy}, 256'b0);
        check_output({name, " done after abort"}, {255'b0, o_done}, 256'b0);
        i_w_valid = 1'b0;
        tick();
        tick();
        rst = 1'b1;
        return;
      end
      i_w_valid = 1'b1;
      i_w       = w[j];
      if (j == illegal_at) begin
        i_start = 1'b1;
        i_init  = 1'b1;
      end
      tick();
      edges++;
      i_start = 1'b0;
      i_init  = 1'b0;
    end

    i_w_valid = 1'b0;
    i_w       = 32'h0;
    check_output({name, " done low in FINAL"}, {255'b0, o_done}, 256'b0);
    check_output({name, " busy in FINAL"}, {255'b0, o_busy}, {255'b0, 1'b1});
    tick();
    edges++;
    check_output({name, " done pulse"}, {255'b0, o_done}, {255'b0, 1'b1});
    check_output({name, " ready with done"}, {255'b0, o_ready}, {255'b0, 1'b1});
    check_output({name, " busy with done"}, {255'b0, o_busy}, 256'b0);
    // 64 word edges plus the FINAL edge after the start edge.
    if (!stalls)
      check_output({name, " latency edges"}, 256'(edges), 256'd65);
  endtask

  initial begin
    abc_blk   = '{0: 32'h61626380, 15: 32'h00000018, default: 32'h0};
    empty_blk = '{0: 32'h80000000, default: 32'h0};
    two_blk1  = '{32'h61626364, 32'h62636465, 32'h63646566, 32'h64656667,
                  32'h65666768, 32'h66676869, 32'h6768696a, 32'h68696a6b,
                  32'h696a6b6c, 32'h6a6b6c6d, 32'h6b6c6d6e, 32'h6c6d6e6f,
                  32'h6d6e6f70, 32'h6e6f7071, 32'h80000000, 32'h00000000};
    two_blk2  = '{15: 32'h000001c0, default: 32'h0};

    rst       = 1'b0;
    i_init    = 1'b0;
    i_start   = 1'b0;
    i_w_valid = 1'b0;
    i_w       = 32'h0;
    #12;
    check_output("reset digest", o_digest, IV_DIGEST);
    check_output("reset ready", {255'b0, o_ready}, {255'b0, 1'b1});
    check_output("reset busy", {255'b0, o_busy}, 256'b0);
    check_output("reset done", {255'b0, o_done}, 256'b0);
    rst = 1'b1;
    tick();

    $display("[TB] abc single block");
    apply_stimulus("abc", 1'b1, abc_blk, 1'b0, -1, -1);
    check_output("abc digest", o_digest, ABC_DIGEST);
    tick();
    check_output("abc done is one cycle", {255'b0, o_done}, 256'b0);
    check_output("abc done count", 256'(done_count), 256'd1);

    $display("[TB] empty message");
    apply_stimulus("empty", 1'b1, empty_blk, 1'b0, -1, -1);
    check_output("empty digest", o_digest, EMPTY_DIGEST);

    $display("[TB] two-block message, back-to-back");
    apply_stimulus("two1", 1'b1, two_blk1, 1'b0, -1, -1);
    apply_stimulus("two2", 1'b0, two_blk2, 1'b0, -1, -1);
    check_output("two-block digest", o_digest, TWO_DIGEST);
    tick();
    check_output("two-block done count", 256'(done_count), 256'd4);

    $display("[TB] abc with stalls");
    apply_stimulus("stall", 1'b1, abc_blk, 1'b1, -1, -1);
    check_output("stall digest", o_digest, ABC_DIGEST);
    tick();
    check_output("stall done count", 256'(done_count), 256'd5);

    $display("[TB] stray words in IDLE");
    i_w_valid = 1'b1;
    for (int j = 0; j < 5; j++) begin
      i_w = $urandom;
      tick();
      check_output("idle stray ready", {255'b0, o_ready}, {255'b0, 1'b1});
    end
    i_w_valid = 1'b0;
    check_output("idle stray digest", o_digest, ABC_DIGEST);
    check_output("idle stray done count", 256'(done_count), 256'd5);

    $display("[TB] start/init pulsed mid-block");
    apply_stimulus("illegal1", 1'b1, two_blk1, 1'b0, -1, -1);
    apply_stimulus("illegal2", 1'b0, two_blk2, 1'b0, 10, -1);
    check_output("illegal digest", o_digest, TWO_DIGEST);
    apply_stimulus("illegal_abc", 1'b1, abc_blk, 1'b0, 10, -1);
    check_output("illegal abc digest", o_digest, ABC_DIGEST);
    tick();
    check_output("illegal done count", 256'(done_count), 256'd8);

    $display("[TB] reset mid-operation");
    apply_stimulus("abort", 1'b1, abc_blk, 1'b0, -1, 30);
    repeat (70) tick();
    check_output("abort no done", 256'(done_count), 256'd8);
    check_output("abort digest idle", o_digest, IV_DIGEST);
    apply_stimulus("fresh", 1'b1, abc_blk, 1'b0, -1, -1);
    check_output("fresh digest", o_digest, ABC_DIGEST);
    tick();
    check_output("fresh done count", 256'(done_count), 256'd9);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
